// File: rtl/tlb_unit.sv
// tlb_unit: fully associative MIPS-style TLB (4 KiB pages) with TLBR/TLBWI/TLBWR,
// a combinational probe, a Random register and a one-cycle registered lookup.

// One entry's comparator, evaluated against both the probe key and the lookup key.
module tlb_match_lane (
  input  logic [18:0] vpn2,
  input  logic [7:0]  asid,
  input  logic        g,
  input  logic [18:0] probe_vpn2,
  input  logic [18:0] lookup_vpn2,
  input  logic [7:0]  cur_asid,
  output logic        probe_hit,
  output logic        lookup_hit
);
  logic asid_ok;
  assign asid_ok    = g | (asid == cur_asid);
  assign probe_hit  = asid_ok & (vpn2 == probe_vpn2);
  assign lookup_hit = asid_ok & (vpn2 == lookup_vpn2);
endmodule

module tlb_unit #(
  parameter int ENTRIES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  TLBop,
  input  logic [31:0] regEntryHiOut,
  input  logic [31:0] regEntryLo0Out,
  input  logic [31:0] regEntryLo1Out,
  input  logic [31:0] regPageMaskOut,
  input  logic [31:0] regIndexOut,
  input  logic [4:0]  regWiredOut,
  input  logic        regWiredWrite,
  output logic [31:0] regEntryHiIn,
  output logic [31:0] regEntryLo0In,
  output logic [31:0] regEntryLo1In,
  output logic [31:0] regPageMaskIn,
  output logic [31:0] regIndexIn,
  output logic [4:0]  regRandomIn,
  input  logic [31:0] vaddr,
  input  logic        lookupReq,
  output logic [31:0] paddr,
  output logic        lookupValid,
  output logic        lookupHit,
  output logic        lookupV,
  output logic        lookupD,
  output logic [2:0]  lookupC
);
  typedef struct packed {
    logic [19:0] pfn;
    logic [2:0]  c;
    logic        d;
    logic        v;
  } tlb_page_t;

  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    logic [15:0] mask;
    tlb_page_t   lo0;
    tlb_page_t   lo1;
  } tlb_entry_t;

  tlb_entry_t entries_q [ENTRIES];
  tlb_entry_t entries_d [ENTRIES];
  logic [4:0] random_q, random_d;

  logic        vld_pipe_q, vld_pipe_d;
  logic        hit_q, hit_d, v_q, v_d, d_q, d_d;
  logic [2:0]  c_q, c_d;
  logic [31:0] paddr_q, paddr_d;

  logic [ENTRIES-1:0] probe_hit_vec, lk_hit_vec;
  logic               probe_any, lk_any;
  logic [4:0]         probe_idx, wr_idx;
  logic               wr_en;
  tlb_entry_t         lk_entry, rd_entry, new_entry;
  tlb_page_t          lk_page;

  logic unused_bits;
  assign unused_bits = ^{regIndexOut[31:5], regEntryHiOut[12:8], regEntryLo0Out[31:26],
                         regEntryLo1Out[31:26], regPageMaskOut[31:29], regPageMaskOut[12:0]};

  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_lane
    tlb_match_lane u_lane (
      .vpn2        (entries_q[gi].vpn2),
      .asid        (entries_q[gi].asid),
      .g           (entries_q[gi].g),
      .probe_vpn2  (regEntryHiOut[31:13]),
      .lookup_vpn2 (vaddr[31:13]),
      .cur_asid    (regEntryHiOut[7:0]),
      .probe_hit   (probe_hit_vec[gi]),
      .lookup_hit  (lk_hit_vec[gi])
    );
  end

  // Lowest-index priority select for probe and lookup; duplicates are silently resolved.
  always_comb begin
    probe_any = 1'b0;
    probe_idx = '0;
    lk_any    = 1'b0;
    lk_entry  = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (probe_hit_vec[i]) begin
        probe_any = 1'b1;
        probe_idx = 5'(i);
      end
      if (lk_hit_vec[i]) begin
        lk_any   = 1'b1;
        lk_entry = entries_q[i];
      end
    end
  end

  assign regIndexIn = {~probe_any, 26'h0, probe_idx};

  // TLBR read-back; an index with no backing entry reads as zeros.
  always_comb begin
    rd_entry = '0;
    for (int i = 0; i < ENTRIES; i++)
      if (regIndexOut[4:0] == 5'(i)) rd_entry = entries_q[i];
  end

  assign regEntryHiIn  = {rd_entry.vpn2, 5'h0, rd_entry.asid};
  assign regEntryLo0In = {6'h0, rd_entry.lo0, rd_entry.g};
  assign regEntryLo1In = {6'h0, rd_entry.lo1, rd_entry.g};
  assign regPageMaskIn = {3'h0, rd_entry.mask, 13'h0};

  // Entry write from the CP0 registers; index out of range writes nothing.
  always_comb begin
    entries_d = entries_q;
    wr_en     = TLBop[1];
    wr_idx    = (TLBop == 2'b11) ? random_q : regIndexOut[4:0];
    new_entry.vpn2 = regEntryHiOut[31:13];
    new_entry.asid = regEntryHiOut[7:0];
    new_entry.g    = regEntryLo0Out[0] & regEntryLo1Out[0];
    new_entry.mask = regPageMaskOut[28:13];
    new_entry.lo0  = regEntryLo0Out[25:1];
    new_entry.lo1  = regEntryLo1Out[25:1];
    for (int i = 0; i < ENTRIES; i++)
      if (wr_en && (wr_idx == 5'(i))) entries_d[i] = new_entry;
  end

  // Random counts down from 31, wrapping back at Wired or at 0.
  always_comb begin
    if (regWiredWrite)
      random_d = 5'd31;
    else if ((random_q <= regWiredOut) || (random_q == 5'd0))
      random_d = 5'd31;
    else
      random_d = random_q - 5'd1;
  end

  assign regRandomIn = random_q;

  // Lookup result computed from pre-write contents, registered for one-cycle latency.
  always_comb begin
    lk_page    = vaddr[12] ? lk_entry.lo1 : lk_entry.lo0;
    vld_pipe_d = lookupReq;
    hit_d      = lookupReq & lk_any;
    paddr_d    = hit_d ? {lk_page.pfn, vaddr[11:0]} : 32'h0;
    v_d        = hit_d & lk_page.v;
    d_d        = hit_d & lk_page.d;
    c_d        = hit_d ? lk_page.c : 3'h0;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) entries_q[i] <= '0;
      random_q   <= 5'd31;
      vld_pipe_q <= 1'b0;
      hit_q      <= 1'b0;
      paddr_q    <= 32'h0;
      v_q        <= 1'b0;
      d_q        <= 1'b0;
      c_q        <= 3'h0;
    end else begin
      entries_q  <= entries_d;
      random_q   <= random_d;
      vld_pipe_q <= vld_pipe_d;
      hit_q      <= hit_d;
      paddr_q    <= paddr_d;
      v_q        <= v_d;
      d_q        <= d_d;
      c_q        <= c_d;
    end
  end

  assign lookupValid = vld_pipe_q;
  assign lookupHit   = hit_q;
  assign paddr       = paddr_q;
  assign lookupV     = v_q;
  assign lookupD     = d_q;
  assign lookupC     = c_q;
endmodule

// File: tb/tb_tlb_unit.sv
// tb_tlb_unit: directed scenarios plus randomized traffic against a word-level reference model.
module tb_tlb_unit;
  localparam int ENTRIES = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  TLBop;
  logic [31:0] regEntryHiOut, regEntryLo0Out, regEntryLo1Out, regPageMaskOut, regIndexOut;
  logic [4:0]  regWiredOut;
  logic        regWiredWrite;
  logic [31:0] regEntryHiIn, regEntryLo0In, regEntryLo1In, regPageMaskIn, regIndexIn;
  logic [4:0]  regRandomIn;
  logic [31:0] vaddr, paddr;
  logic        lookupReq, lookupValid, lookupHit, lookupV, lookupD;
  logic [2:0]  lookupC;

  always #5 clk = ~clk;

  tlb_unit #(.ENTRIES(ENTRIES)) dut (
    .clk(clk), .rst(rst), .TLBop(TLBop),
    .regEntryHiOut(regEntryHiOut), .regEntryLo0Out(regEntryLo0Out),
    .regEntryLo1Out(regEntryLo1Out), .regPageMaskOut(regPageMaskOut),
    .regIndexOut(regIndexOut), .regWiredOut(regWiredOut), .regWiredWrite(regWiredWrite),
    .regEntryHiIn(regEntryHiIn), .regEntryLo0In(regEntryLo0In),
    .regEntryLo1In(regEntryLo1In), .regPageMaskIn(regPageMaskIn),
    .regIndexIn(regIndexIn), .regRandomIn(regRandomIn),
    .vaddr(vaddr), .lookupReq(lookupReq), .paddr(paddr),
    .lookupValid(lookupValid), .lookupHit(lookupHit),
    .lookupV(lookupV), .lookupD(lookupD), .lookupC(lookupC)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: entries kept as the words TLBR should return.
  logic [31:0] m_hi [ENTRIES];
  logic [31:0] m_lo0 [ENTRIES];
  logic [31:0] m_lo1 [ENTRIES];
  logic [31:0] m_pm [ENTRIES];
  int          m_rand;
  logic        e_valid, e_hit, e_v, e_d;
  logic [2:0]  e_c;
  logic [31:0] e_paddr;

  function automatic int match(input logic [18:0] vpn, input logic [7:0] asid);
    for (int i = 0; i < ENTRIES; i++)
      if (m_hi[i][31:13] == vpn && (m_lo0[i][0] || m_hi[i][7:0] == asid)) return i;
    return -1;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < ENTRIES; i++) begin
      m_hi[i] = 0; m_lo0[i] = 0; m_lo1[i] = 0; m_pm[i] = 0;
    end
    m_rand = 31;
  endtask

  // One clock: check combinational outputs, advance model at the edge, check lookup outputs.
  task automatic step();
    int pi, li, wi, ri;
    logic [31:0] lo, g;
    logic n_valid, n_hit, n_v, n_d;
    logic [2:0] n_c;
    logic [31:0] n_paddr;
    #1;
    chk("random", 32'(regRandomIn), 32'(m_rand));
    pi = match(regEntryHiOut[31:13], regEntryHiOut[7:0]);
    chk("probe", regIndexIn, (pi < 0) ? 32'h8000_0000 : 32'(pi));
    ri = int'(regIndexOut[4:0]);
    chk("tlbr_hi", regEntryHiIn, (ri < ENTRIES) ? m_hi[ri] : 32'h0);
    chk("tlbr_lo0", regEntryLo0In, (ri < ENTRIES) ? m_lo0[ri] : 32'h0);
    chk("tlbr_lo1", regEntryLo1In, (ri < ENTRIES) ? m_lo1[ri] : 32'h0);
    chk("tlbr_pm", regPageMaskIn, (ri < ENTRIES) ? m_pm[ri] : 32'h0);
    li = match(vaddr[31:13], regEntryHiOut[7:0]);
    n_valid = lookupReq && !rst;
    n_hit = n_valid && (li >= 0);
    n_paddr = 0; n_v = 0; n_d = 0; n_c = 0;
    if (n_hit) begin
      lo = vaddr[12] ? m_lo1[li] : m_lo0[li];
      n_paddr = {lo[25:6], vaddr[11:0]};
      n_c = lo[5:3]; n_d = lo[2]; n_v = lo[1];
    end
    wi = -1;
    if (TLBop == 2'b10) wi = int'(regIndexOut[4:0]);
    else if (TLBop == 2'b11) wi = m_rand;
    @(posedge clk);
    if (rst) begin
      model_clear();
    end else begin
      if (wi >= 0 && wi < ENTRIES) begin
        g = {31'h0, regEntryLo0Out[0] & regEntryLo1Out[0]};
        m_hi[wi]  = regEntryHiOut & 32'hFFFF_E0FF;
        m_lo0[wi] = (regEntryLo0Out & 32'h03FF_FFFE) | g;
        m_lo1[wi] = (regEntryLo1Out & 32'h03FF_FFFE) | g;
        m_pm[wi]  = regPageMaskOut & 32'h1FFF_E000;
      end
      if (regWiredWrite || m_rand <= int'(regWiredOut) || m_rand == 0) m_rand = 31;
      else m_rand = m_rand - 1;
    end
    e_valid = n_valid; e_hit = n_hit; e_paddr = n_paddr;
    e_v = n_v; e_d = n_d; e_c = n_c;
    #1;
    chk("lk_valid", 32'(lookupValid), 32'(e_valid));
    chk("lk_hit", 32'(lookupHit), 32'(e_hit));
    chk("lk_paddr", paddr, e_paddr);
    chk("lk_vdc", {27'h0, lookupV, lookupD, lookupC}, {27'h0, e_v, e_d, e_c});
  endtask

  task automatic idle();
    rst = 0; TLBop = 2'b00; lookupReq = 0; regWiredWrite = 0;
  endtask

  task automatic write_entry(input logic [1:0] op, input logic [31:0] idx, input logic [31:0] hi,
                             input logic [31:0] lo0, input logic [31:0] lo1, input logic [31:0] pm);
    TLBop = op; regIndexOut = idx; regEntryHiOut = hi;
    regEntryLo0Out = lo0; regEntryLo1Out = lo1; regPageMaskOut = pm;
    step();
    TLBop = 2'b00;
  endtask

  function automatic logic [18:0] pick_vpn();
    case ($urandom_range(0, 3))
      0: return 19'h00201;
      1: return 19'h00600;
      2: return 19'h00000;
      default: return 19'h7FFFF;
    endcase
  endfunction

  function automatic logic [7:0] pick_asid();
    case ($urandom_range(0, 2))
      0: return 8'hA5;
      1: return 8'hA6;
      default: return 8'h00;
    endcase
  endfunction

  initial begin
    rst = 1; TLBop = 0; regEntryHiOut = 0; regEntryLo0Out = 0; regEntryLo1Out = 0;
    regPageMaskOut = 0; regIndexOut = 0; regWiredOut = 0; regWiredWrite = 0;
    vaddr = 0; lookupReq = 0;
    repeat (2) @(posedge clk);
    #1;
    model_clear();
    e_valid = 0; e_hit = 0; e_v = 0; e_d = 0; e_c = 0; e_paddr = 0;
    chk("rst_random", 32'(regRandomIn), 32'd31);
    chk("rst_valid", 32'(lookupValid), 32'd0);
    chk("rst_hit", 32'(lookupHit), 32'd0);
    chk("rst_paddr", paddr, 32'h0);
    chk("rst_entry_hi", regEntryHiIn, 32'h0);
    idle();

    // Random walk with Wired = 0, then Wired = 8 floor
    for (int k = 0; k <= 32; k++) begin
      chk("rand_seq", 32'(regRandomIn), (k == 32) ? 32'd31 : 32'(31 - k));
      step();
    end
    regWiredOut = 5'd8; regWiredWrite = 1;
    step();
    regWiredWrite = 0;
    chk("rand_wired_write", 32'(regRandomIn), 32'd31);
    for (int k = 0; k < 40; k++) begin
      step();
      chk("rand_floor", 32'(regRandomIn >= 5'd8), 32'd1);
    end

    // TLBWI then TLBR
    write_entry(2'b10, 32'd5, 32'h0040_20A5, 32'h0000_1F07, 32'h0000_2007, 32'h0000_6000);
    chk("tlbr5_hi", regEntryHiIn, 32'h0040_20A5);
    chk("tlbr5_lo0", regEntryLo0In, 32'h0000_1F07);
    chk("tlbr5_lo1", regEntryLo1In, 32'h0000_2007);
    chk("tlbr5_pm", regPageMaskIn, 32'h0000_6000);

    // Probe: exact hit, global hit on other ASID, miss once G cleared
    regEntryHiOut = 32'h0040_20A5; #1;
    chk("probe_hit", regIndexIn, 32'h0000_0005);
    regEntryHiOut = 32'h0040_20A6; #1;
    chk("probe_global", regIndexIn, 32'h0000_0005);
    write_entry(2'b10, 32'd5, 32'h0040_20A5, 32'h0000_1F06, 32'h0000_2007, 32'h0000_6000);
    regEntryHiOut = 32'h0040_20A6; #1;
    chk("probe_miss", regIndexIn, 32'h8000_0000);

    // Lookup of odd page
    regEntryHiOut = 32'h0000_00A5; vaddr = 32'h0040_3ABC; lookupReq = 1;
    step();
    lookupReq = 0;
    chk("lk_dir_valid", 32'(lookupValid), 32'd1);
    chk("lk_dir_hit", 32'(lookupHit), 32'd1);
    chk("lk_dir_paddr", paddr, 32'h0008_0ABC);
    chk("lk_dir_dv", {30'h0, lookupD, lookupV}, 32'h3);

    // Write/lookup collision: pre-write contents, then visible next cycle
    vaddr = 32'h00C0_0123; lookupReq = 1;
    write_entry(2'b11, 32'd0, 32'h00C0_00A5, 32'h0000_1F07, 32'h0000_2007, 32'h0);
    chk("coll_valid", 32'(lookupValid), 32'd1);
    chk("coll_miss", 32'(lookupHit), 32'd0);
    step();
    lookupReq = 0;
    chk("coll_hit", 32'(lookupHit), 32'd1);
    chk("coll_paddr", paddr, 32'h0007_C123);

    // Duplicate match resolves to lowest index
    write_entry(2'b10, 32'd7, 32'h00E0_00A5, 32'h0000_0A03, 32'h0000_0B03, 32'h0);
    write_entry(2'b10, 32'd3, 32'h00E0_00A5, 32'h0000_0C03, 32'h0000_0D03, 32'h0);
    chk("dup_probe", regIndexIn, 32'h0000_0003);

    // Reset during a lookup suppresses its result
    rst = 1; lookupReq = 1; vaddr = 32'h0040_3ABC;
    step();
    idle();
    chk("rst_lk_valid", 32'(lookupValid), 32'd0);
    chk("rst_lk_random", 32'(regRandomIn), 32'd31);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      TLBop = 2'($urandom_range(0, 3));
      regIndexOut = $urandom;
      regEntryHiOut = {pick_vpn(), 5'($urandom), pick_asid()};
      regEntryLo0Out = $urandom;
      regEntryLo1Out = $urandom;
      regPageMaskOut = $urandom;
      if ($urandom_range(0, 31) == 0) begin
        regWiredOut = 5'($urandom_range(0, 31));
        regWiredWrite = 1;
      end else begin
        regWiredWrite = 0;
      end
      lookupReq = 1'($urandom_range(0, 1));
      vaddr = {pick_vpn(), 13'($urandom)};
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
